// File: rtl/tx_phy_sched_pkg.sv
// Shared constants, state encoding and width helper for the Alink TX PHY scheduler.
package tx_phy_sched_pkg;

  localparam int unsigned TX_TASKID_LEN  = 12;
  localparam int unsigned TX_DATA_LEN    = 8;
  localparam int unsigned TASK_WORDS_DEF = TX_TASKID_LEN + TX_DATA_LEN;
  localparam int unsigned WD_CYCLES_DEF  = 65536;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } sched_state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/tx_phy_sched_if.sv
// Scheduler <-> TX PHY handshake: start/select out, done back, flush out.
interface tx_phy_sched_if #(
  parameter int unsigned NCH = 32
);

  logic           tx_phy_start;
  logic [NCH-1:0] tx_phy_sel;
  logic           tx_phy_done;
  logic           tx_flush;

  modport master (
    output tx_phy_start,
    output tx_phy_sel,
    output tx_flush,
    input  tx_phy_done
  );

  modport slave (
    input  tx_phy_start,
    input  tx_phy_sel,
    input  tx_flush,
    output tx_phy_done
  );

endinterface

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin arbiter: first request above last_i, wrapping modulo N.
module rr_arb_onehot
  import tx_phy_sched_pkg::*;
#(
  parameter  int unsigned N  = 32,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  always_comb begin
    int unsigned idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last_i) + k;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[IW'(idx)]) begin
        any_o            = 1'b1;
        gnt_idx_o        = IW'(idx);
        gnt_o[IW'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_phy_sched.sv
// Round-robin TX PHY dispatcher: grants a channel when the TxFIFO holds a full task,
// pulses start/select, waits for done under a watchdog, then enforces an idle gap.
module tx_phy_sched
  import tx_phy_sched_pkg::*;
#(
  parameter int unsigned NCH        = 32,
  parameter int unsigned TASK_WORDS = TASK_WORDS_DEF,
  parameter int unsigned FIFO_CW    = 10,
  parameter int unsigned WD_CYCLES  = WD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_flush,
  input  logic [NCH-1:0]     reg_phy_en,
  input  logic [15:0]        reg_gap,
  input  logic               reg_err_clr,
  input  logic [FIFO_CW-1:0] txfifo_cnt,
  input  logic [NCH-1:0]     rx_done,
  tx_phy_sched_if.master     phy,
  output logic [NCH-1:0]     ch_busy,
  output logic               sched_err,
  output logic [31:0]        dispatch_cnt
);

  localparam int unsigned        IW           = idx_width(NCH);
  localparam int unsigned        WW           = idx_width(WD_CYCLES);
  localparam logic [FIFO_CW-1:0] TASK_WORDS_W = FIFO_CW'(TASK_WORDS);
  localparam logic [WW-1:0]      WD_LAST      = WW'(WD_CYCLES - 1);

  if (TASK_WORDS > (2 ** FIFO_CW) - 1) begin : g_bad_task_words
    $error("TASK_WORDS does not fit in txfifo_cnt");
  end
  if (WD_CYCLES < 2) begin : g_bad_wd_cycles
    $error("WD_CYCLES must be at least 2");
  end

  sched_state_e   state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  last_q, last_d;
  logic [NCH-1:0] sel_q, sel_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic           err_q, err_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [15:0]    gap_q, gap_d;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;
  logic [NCH-1:0] grant_oh;
  logic [15:0]    gap_load;
  logic           start;
  logic           wd_fire;

  assign eligible = reg_phy_en & ~busy_q;
  assign grant_oh = NCH'(1) << grant_q;
  assign gap_load = (reg_gap == '0) ? 16'd1 : reg_gap;

  rr_arb_onehot #(
    .N (NCH)
  ) u_arb (
    .req_i     (eligible),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    sel_d   = sel_q;
    busy_d  = busy_q & ~rx_done;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    start   = 1'b0;
    wd_fire = 1'b0;

    if (reg_err_clr) err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_any && (txfifo_cnt >= TASK_WORDS_W)) begin
          grant_d = arb_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        start          = 1'b1;
        busy_d[grant_q] = 1'b1;
        sel_d          = grant_oh;
        last_d         = grant_q;
        cnt_d          = cnt_q + 32'd1;
        wd_d           = '0;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a simultaneous watchdog expiry
        if (phy.tx_phy_done) begin
          gap_d   = gap_load;
          state_d = S_GAP;
        end else if (wd_q == WD_LAST) begin
          wd_fire         = 1'b1;
          err_d           = 1'b1;
          busy_d[grant_q] = 1'b0;
          gap_d           = gap_load;
          state_d         = S_GAP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_GAP: begin
        if (gap_q <= 16'd1) state_d = S_IDLE;
        else                gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides the FSM but keeps arbitration history, count and error flag.
    if (reg_flush) begin
      state_d = S_IDLE;
      grant_d = grant_q;
      last_d  = last_q;
      sel_d   = sel_q;
      busy_d  = '0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      wd_d    = '0;
      gap_d   = '0;
      start   = 1'b0;
      wd_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NCH - 1);
      sel_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign phy.tx_phy_start = start;
  assign phy.tx_phy_sel   = start ? grant_oh : sel_q;
  assign phy.tx_flush     = reg_flush | wd_fire;
  assign ch_busy          = busy_q;
  assign sched_err        = err_q;
  assign dispatch_cnt     = cnt_q;

endmodule

// File: tb/tb_tx_phy_sched.sv
// Directed bench for tx_phy_sched: dispatch latency, round-robin, FIFO threshold,
// busy blocking, watchdog, flush and mid-frame reset.
module tb_tx_phy_sched;

  localparam int unsigned NCH = 32;

  logic           clk;
  logic           rst;
  logic           reg_flush;
  logic [NCH-1:0] reg_phy_en;
  logic [15:0]    reg_gap;
  logic           reg_err_clr;
  logic [9:0]     txfifo_cnt;
  logic [NCH-1:0] rx_done;
  logic [NCH-1:0] ch_busy;
  logic           sched_err;
  logic [31:0]    dispatch_cnt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          n;
  int          cnt_starts;

  tx_phy_sched_if #(.NCH(NCH)) phy_if ();

  tx_phy_sched #(
    .NCH        (NCH),
    .TASK_WORDS (20),
    .FIFO_CW    (10),
    .WD_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_flush    (reg_flush),
    .reg_phy_en   (reg_phy_en),
    .reg_gap      (reg_gap),
    .reg_err_clr  (reg_err_clr),
    .txfifo_cnt   (txfifo_cnt),
    .rx_done      (rx_done),
    .phy          (phy_if),
    .ch_busy      (ch_busy),
    .sched_err    (sched_err),
    .dispatch_cnt (dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_start(input int max, input string tag, output int cycles);
    cycles = 0;
    while (phy_if.tx_phy_start !== 1'b1 && cycles < max) begin
      cyc();
      cycles++;
    end
    chk({tag, "_start"}, 32'(phy_if.tx_phy_start), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reg_flush = 1'b0; reg_phy_en = '0; reg_gap = '0; reg_err_clr = 1'b0;
    txfifo_cnt = '0; rx_done = '0; phy_if.tx_phy_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic count_starts(input int cycles, output int starts);
    starts = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (phy_if.tx_phy_start === 1'b1) starts++;
    end
  endtask

  initial begin
    logic [NCH-1:0] rr_exp [4];
    rr_exp[0] = 32'h1; rr_exp[1] = 32'h2; rr_exp[2] = 32'h4; rr_exp[3] = 32'h1;

    // reset state
    rst = 1'b1;
    reg_flush = 1'b0; reg_phy_en = '0; reg_gap = '0; reg_err_clr = 1'b0;
    txfifo_cnt = '0; rx_done = '0; phy_if.tx_phy_done = 1'b0;
    cyc();
    cyc();
    chk("rst_start", 32'(phy_if.tx_phy_start), 32'd0);
    chk("rst_sel",   phy_if.tx_phy_sel, 32'h0);
    chk("rst_busy",  ch_busy, 32'h0);
    chk("rst_err",   32'(sched_err), 32'd0);
    chk("rst_cnt",   dispatch_cnt, 32'd0);
    chk("rst_flush", 32'(phy_if.tx_flush), 32'd0);

    // single channel dispatch, 4-cycle gap
    rst = 1'b0; reg_phy_en = 32'h1; txfifo_cnt = 10'd20; reg_gap = 16'd4;
    cyc();
    chk("t1_start",  32'(phy_if.tx_phy_start), 32'd1);
    chk("t1_sel",    phy_if.tx_phy_sel, 32'h1);
    chk("t1_busy_s", ch_busy, 32'h0);
    cyc();
    chk("t1_start_off", 32'(phy_if.tx_phy_start), 32'd0);
    chk("t1_sel_hold",  phy_if.tx_phy_sel, 32'h1);
    chk("t1_busy",      ch_busy, 32'h1);
    chk("t1_cnt",       dispatch_cnt, 32'd1);
    phy_if.tx_phy_done = 1'b1;
    cyc();
    phy_if.tx_phy_done = 1'b0; rx_done = 32'h1;
    cyc();
    rx_done = '0;
    chk("t1_rx_clear", ch_busy, 32'h0);
    cyc();
    cyc();
    cyc();
    chk("t1_gap_idle", 32'(phy_if.tx_phy_start), 32'd0);
    cyc();
    chk("t1_restart", 32'(phy_if.tx_phy_start), 32'd1);
    chk("t1_resel",   phy_if.tx_phy_sel, 32'h1);
    cyc();
    chk("t1_cnt2", dispatch_cnt, 32'd2);

    // round robin over three channels
    do_reset();
    reg_phy_en = 32'h7; txfifo_cnt = 10'd20; reg_gap = 16'd1;
    for (int i = 0; i < 4; i++) begin
      wait_start(8, "t2", n);
      chk("t2_sel", phy_if.tx_phy_sel, rr_exp[i]);
      cyc();
      phy_if.tx_phy_done = 1'b1; rx_done = rr_exp[i];
      cyc();
      phy_if.tx_phy_done = 1'b0; rx_done = '0;
    end
    chk("t2_cnt", dispatch_cnt, 32'd4);

    // FIFO threshold
    do_reset();
    reg_phy_en = 32'h1; txfifo_cnt = 10'd19; reg_gap = 16'd1;
    count_starts(10, cnt_starts);
    chk("t3_nostart", 32'(cnt_starts), 32'd0);
    txfifo_cnt = 10'd20;
    wait_start(2, "t3", n);
    chk("t3_latency", 32'(n), 32'd1);

    // busy channel is skipped until rx_done returns it
    do_reset();
    reg_phy_en = 32'h1; txfifo_cnt = 10'd20; reg_gap = 16'd1;
    wait_start(8, "t4a", n);
    chk("t4_sel0", phy_if.tx_phy_sel, 32'h1);
    cyc();
    phy_if.tx_phy_done = 1'b1;
    cyc();
    phy_if.tx_phy_done = 1'b0; reg_phy_en = 32'h3;
    wait_start(8, "t4b", n);
    chk("t4_sel1", phy_if.tx_phy_sel, 32'h2);
    cyc();
    chk("t4_busy", ch_busy, 32'h3);
    phy_if.tx_phy_done = 1'b1;
    cyc();
    phy_if.tx_phy_done = 1'b0;
    count_starts(10, cnt_starts);
    chk("t4_blocked", 32'(cnt_starts), 32'd0);
    rx_done = 32'h1;
    cyc();
    rx_done = '0;
    wait_start(8, "t4c", n);
    chk("t4_sel_ret", phy_if.tx_phy_sel, 32'h1);

    // watchdog expiry at WAIT cycle 15, then done-wins at the same cycle
    do_reset();
    reg_phy_en = 32'h1; txfifo_cnt = 10'd20; reg_gap = 16'd2;
    wait_start(8, "t5a", n);
    cyc();
    for (int k = 0; k < 16; k++) begin
      chk("t5_flush", 32'(phy_if.tx_flush), (k == 15) ? 32'd1 : 32'd0);
      if (k < 15) cyc();
    end
    chk("t5_err_pre", 32'(sched_err), 32'd0);
    cyc();
    chk("t5_flush_off", 32'(phy_if.tx_flush), 32'd0);
    chk("t5_err",       32'(sched_err), 32'd1);
    chk("t5_busy_clr",  ch_busy, 32'h0);
    reg_err_clr = 1'b1;
    cyc();
    reg_err_clr = 1'b0;
    chk("t5_err_clr", 32'(sched_err), 32'd0);
    wait_start(8, "t5b", n);
    cyc();
    repeat (15) cyc();
    phy_if.tx_phy_done = 1'b1;
    #1;
    chk("t5_done_wins_flush", 32'(phy_if.tx_flush), 32'd0);
    cyc();
    phy_if.tx_phy_done = 1'b0;
    chk("t5_done_wins_err",  32'(sched_err), 32'd0);
    chk("t5_done_wins_busy", ch_busy, 32'h1);

    // flush in WAIT with two channels busy
    do_reset();
    reg_phy_en = 32'h5; txfifo_cnt = 10'd20; reg_gap = 16'd1;
    wait_start(8, "t6a", n);
    chk("t6_sel0", phy_if.tx_phy_sel, 32'h1);
    cyc();
    phy_if.tx_phy_done = 1'b1;
    cyc();
    phy_if.tx_phy_done = 1'b0;
    wait_start(8, "t6b", n);
    chk("t6_sel2", phy_if.tx_phy_sel, 32'h4);
    cyc();
    chk("t6_busy", ch_busy, 32'h5);
    chk("t6_cnt",  dispatch_cnt, 32'd2);
    reg_flush = 1'b1;
    #1;
    chk("t6_flush_comb", 32'(phy_if.tx_flush), 32'd1);
    cyc();
    chk("t6_busy_clr", ch_busy, 32'h0);
    chk("t6_cnt_hold", dispatch_cnt, 32'd2);
    chk("t6_nostart0", 32'(phy_if.tx_phy_start), 32'd0);
    count_starts(6, cnt_starts);
    chk("t6_nostart", 32'(cnt_starts), 32'd0);
    reg_flush = 1'b0;
    #1;
    chk("t6_flush_off", 32'(phy_if.tx_flush), 32'd0);
    wait_start(4, "t6c", n);
    chk("t6_sel_after", phy_if.tx_phy_sel, 32'h1);

    // reset while in START
    rst = 1'b1;
    cyc();
    chk("t7_start", 32'(phy_if.tx_phy_start), 32'd0);
    chk("t7_busy",  ch_busy, 32'h0);
    chk("t7_cnt",   dispatch_cnt, 32'd0);
    chk("t7_sel",   phy_if.tx_phy_sel, 32'h0);
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
